// File: rtl/mem_access_unit_if.sv
// Bundles the pipeline request/response handshake and the word-memory bus
// of the memory access unit. The unit sits on the slave side. The master
// side is the pipeline plus the memory.
interface mem_access_unit_if #(
  parameter int ADDR_W = 15
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [31:0]       mem_wdata;
  logic              mem_data_ready;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_data_ready, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
    output mem_cs, mem_we, mem_addr, mem_data_valid, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_data_ready, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
    input  mem_cs, mem_we, mem_addr, mem_data_valid, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Core-side initiator for the chip_select/data_ready word memory.
// Runs one load or store at a time. Sub-word stores become read-modify-write.
// Load data is aligned and extended. Misaligned requests, illegal requests
// and handshake timeouts are reported through resp_err.
module mem_access_unit #(
  parameter int ADDR_W  = 15,
  parameter int TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rst_n,
  mem_access_unit_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    CAPTURE,
    WRITE,
    RELEASE,
    RESP,
    ERR_RESP,
    TIMEOUT_ERR
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              rdy_meta;
  logic              rdy_s;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_expired;
  logic              accept;
  logic              misaligned;
  logic              req_ready;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       load_q;
  logic [31:0]       merge_d;
  logic [31:0]       load_d;
  logic [31:0]       shifted;

  // Two-flop synchroniser for the asynchronous memory data_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_meta <= 1'b0;
      rdy_s    <= 1'b0;
    end else begin
      rdy_meta <= bus.mem_data_ready;
      rdy_s    <= rdy_meta;
    end
  end

  // Classify the incoming request as legal or misaligned/illegal.
  always_comb begin
    misaligned = 1'b0;
    case (bus.req_size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = bus.req_addr[0];
      2'd2:    misaligned = |bus.req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // New requests wait until the previous access has fully released data_ready.
  // This keeps one chip_select edge per access, even after a timeout in RELEASE.
  assign req_ready   = (state == IDLE) && !rdy_s;
  assign accept      = bus.req_valid && req_ready;
  assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic of the access sequence.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = misaligned ? ERR_RESP : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (rdy_s) begin
          next_state = CAPTURE;
        end else if (cnt_expired) begin
          next_state = TIMEOUT_ERR;
        end
      end
      CAPTURE: next_state = we_q ? WRITE : RELEASE;
      WRITE:   next_state = RELEASE;
      RELEASE: begin
        if (!rdy_s) begin
          next_state = RESP;
        end else if (cnt_expired) begin
          next_state = TIMEOUT_ERR;
        end
      end
      RESP:        next_state = IDLE;
      ERR_RESP:    next_state = IDLE;
      TIMEOUT_ERR: next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  // Wait counter: restarts on every state change and counts while waiting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state != next_state) begin
      cnt <= '0;
    end else if (state == WAIT_RDY || state == RELEASE) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Store merge and load alignment of the word returned by memory.
  always_comb begin
    merge_d = bus.mem_rdata;
    shifted = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    load_d  = bus.mem_rdata;
    case (size_q)
      2'd0: begin
        merge_d[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        load_d = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        merge_d[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        load_d = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      end
      default: begin
        merge_d = wdata_q;
        load_d  = bus.mem_rdata;
      end
    endcase
  end

  // Latch the request on accept and the memory word in CAPTURE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      load_q  <= '0;
    end else if (accept) begin
      we_q    <= bus.req_we;
      uns_q   <= bus.req_unsigned;
      size_q  <= bus.req_size;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end else if (state == CAPTURE) begin
      merge_q <= merge_d;
      load_q  <= load_d;
    end
  end

  // Output decode from the current state.
  always_comb begin
    bus.req_ready      = req_ready;
    bus.mem_cs         = (state == WAIT_RDY) || (state == CAPTURE) || (state == WRITE);
    bus.mem_we         = bus.mem_cs && we_q;
    bus.mem_addr       = bus.mem_cs ? addr_q : '0;
    bus.mem_data_valid = (state == WRITE);
    bus.mem_wdata      = (state == WRITE) ? merge_q : 32'd0;
    bus.resp_valid     = (state == RESP) || (state == ERR_RESP) || (state == TIMEOUT_ERR);
    bus.resp_err       = (state == ERR_RESP) || (state == TIMEOUT_ERR);
    bus.resp_rdata     = ((state == RESP) && !we_q) ? load_q : 32'd0;
  end

endmodule
